fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch front end of the LEGv8 core, sitting between the PC register, instruction memory and decode. It is the writer side of the PC register. It drives the PC write port (`PCWE`, `PCNext`) from the fetched PC, its sequential increment or a branch redirect. It issues one instruction-memory request at a time, buffers returned instructions with their PCs in a small FIFO, and hands them to decode over a valid/ready handshake. It also initialises the PC register, which has no reset of its own, to 0 after reset.

## Interface
Parameters:
- `ADDR_W`, 64: PC / address width.
- `INSTR_W`, 32: instruction width.
- `DEPTH`, 2: instruction FIFO entries (power of two, ≥2).

Ports:
- `CLOCK`  in  1: single clock, rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `PCCur`  in  ADDR_W: current PC, from the PC register output.
- `PCWE`  out  1: PC register write enable.
- `PCNext`  out  ADDR_W: PC register write data.
- `IMemReqValid`  out  1: fetch request valid.
- `IMemReqAddr`  out  ADDR_W: fetch address.
- `IMemReqReady`  in  1: memory accepts request.
- `IMemRespValid`  in  1: response valid, one-cycle pulse.
- `IMemRespData`  in  INSTR_W: instruction word.
- `InstrValid`  out  1: instruction available to decode.
- `InstrData`  out  INSTR_W: instruction at FIFO head.
- `InstrPC`  out  ADDR_W: PC of that instruction.
- `InstrReady`  in  1: decode consumes head.
- `Redirect`  in  1: taken branch / CBZ / exception, one-cycle pulse.
- `RedirectTarget`  in  ADDR_W: new PC.

## Operation
- States: `INIT`, `FETCH`, `WAIT`, `DROP`.
- `INIT` is entered on `RESET`.
  - It drives `PCWE`=1, `PCNext`=0 for exactly one cycle, then goes to `FETCH`.
- `FETCH`:
  - `IMemReqValid` = (count + 0 < DEPTH) & !`Redirect`.
  - `IMemReqAddr` = `PCCur` (combinational).
  - On valid & ready, latch `PCCur` as the tag, drive `PCWE`=1 and `PCNext`=`PCCur`+4 (mod 2^ADDR_W), and go to `WAIT`.
- `WAIT`:
  - No request is issued.
  - On `IMemRespValid`, push {tag, data} into the FIFO and go to `FETCH`.
- Redirect, in any state except `INIT`:
  - Drive `PCWE`=1 and `PCNext`={`RedirectTarget`[ADDR_W-1:2], 2'b00}. This has priority over the +4 write.
  - Flush the FIFO (count←0).
  - From `WAIT` without a same-cycle response, go to `DROP`.
  - From `WAIT` with a same-cycle response, discard the response and go to `FETCH`.
  - In `FETCH` the request is suppressed that cycle.
  - In `DROP`, restart the drop.
- `DROP`: the next `IMemRespValid` is discarded (no push), then go to `FETCH`.
- Only one request is outstanding at a time. Requests are counted as taken only on valid & ready in the same cycle, so the memory must not latch a request whose valid was low.
- FIFO:
  - Push when the response is accepted; pop on `InstrValid` & `InstrReady`.
  - `InstrValid` = (count ≠ 0).
  - `InstrData` and `InstrPC` are read from the head entry.
  - A request is issued only when count + outstanding < DEPTH, so no push ever overflows.
  - Simultaneous push and pop leaves count unchanged.
  - Flush wins over push and pop in the same cycle.
- `PCWE` is 0 in every cycle not listed above.

## Timing
- Reset values, registered outputs: state=`INIT`, count=0, FIFO pointers=0, `InstrValid`=0.
  - `PCWE` is 1 in the first cycle after `RESET` falls, and 0 while `RESET` is high.
  - `IMemReqValid`=0 while `RESET` is high and in `INIT`.
- `RESET` asserted mid-transaction: state returns to `INIT` and the FIFO empties. Any response arriving later in `INIT`/`FETCH` is ignored.
- Request accept → PC updated: the next rising edge. `PCCur` shows PC+4 one cycle after accept.
- Response → `InstrValid`: 1 cycle (registered FIFO).
- Redirect → first request at the target: 1 cycle after the redirect if no response is outstanding. Otherwise 1 cycle after the dropped response.
- Best-case throughput: one instruction per 2 cycles with 1-cycle memory latency.
- `InstrData` and `InstrPC` are stable while `InstrValid` & !`InstrReady`.

## Test plan
- Reset, then memory ready with 1-cycle latency and decode always ready. Required: PC writes 0, 4, 8, 12. Decode sees `InstrPC` 0, 4, 8 with the matching words. `PCWE` is 1 in cycle 1 after reset.
- Decode stalled (`InstrReady`=0). Required: exactly DEPTH=2 instructions buffered (PC 0, 4), then `IMemReqValid` stays 0 and the PC holds at 8. Releasing the stall drains 0, 4 in order and resumes fetch at 8.
- Redirect to 0x1003 while a request is outstanding at 0x10. Required: `PCNext`=0x1000 with `PCWE`=1. The 0x10 response is dropped and the FIFO is emptied. The next request goes to 0x1000 and decode next sees `InstrPC`=0x1000.
- Redirect in the same cycle as a response and a pop. Required: the response is discarded, count is 0, and the next fetch is at the target.
- PC at 0xFFFF_FFFF_FFFF_FFFC, request accepted. Required: `PCNext` wraps to 0.
- `RESET` held 1 cycle in `WAIT`, memory responds 2 cycles later. Required: the response is ignored, the PC is rewritten to 0, and decode sees `InstrPC`=0 first.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: PC register write port, instruction-memory request/response,
// decode handshake and branch redirect. master = fetch_sequencer, slave = its environment.
interface fetch_sequencer_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
);
   logic [ADDR_W-1:0]  PCCur;
   logic               PCWE;
   logic [ADDR_W-1:0]  PCNext;

   logic               IMemReqValid;
   logic [ADDR_W-1:0]  IMemReqAddr;
   logic               IMemReqReady;
   logic               IMemRespValid;
   logic [INSTR_W-1:0] IMemRespData;

   logic               InstrValid;
   logic [INSTR_W-1:0] InstrData;
   logic [ADDR_W-1:0]  InstrPC;
   logic               InstrReady;

   logic               Redirect;
   logic [ADDR_W-1:0]  RedirectTarget;

   modport master (
      input  PCCur,
      output PCWE, PCNext,
      output IMemReqValid, IMemReqAddr,
      input  IMemReqReady, IMemRespValid, IMemRespData,
      output InstrValid, InstrData, InstrPC,
      input  InstrReady,
      input  Redirect, RedirectTarget
   );

   modport slave (
      output PCCur,
      input  PCWE, PCNext,
      input  IMemReqValid, IMemReqAddr,
      output IMemReqReady, IMemRespValid, IMemRespData,
      input  InstrValid, InstrData, InstrPC,
      output InstrReady,
      output Redirect, RedirectTarget
   );
endinterface

// File: rtl/fetch_sequencer.sv
// LEGv8 instruction-fetch front end: owns the PC register write port, keeps one
// memory request in flight and buffers returned words with their PCs for decode.
module fetch_sequencer #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 2
) (
   input  logic              CLOCK,
   input  logic              RESET,
   fetch_sequencer_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {INIT, FETCH, WAIT, DROP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_next;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               instr_valid;
   logic [ADDR_W-1:0]  tag;

   logic [INSTR_W-1:0] data_mem [DEPTH];
   logic [ADDR_W-1:0]  pc_mem   [DEPTH];

   logic               redirect_live;
   logic               req_valid;
   logic               accept;
   logic               push;
   logic               pop;
   logic               pc_we;
   logic [ADDR_W-1:0]  pc_next;

   // The PC register powers up unknown, so INIT is the only place it gets a value;
   // a redirect arriving while it is still being seeded is deliberately ignored.
   assign redirect_live = bus.Redirect & (state != INIT) & ~RESET;

   // Only one request is ever outstanding, so the FIFO count alone bounds issue.
   assign req_valid = ~RESET & (state == FETCH) & (count < CNT_W'(DEPTH)) & ~bus.Redirect;
   assign accept    = req_valid & bus.IMemReqReady;
   assign push      = ~RESET & (state == WAIT) & bus.IMemRespValid & ~redirect_live;
   assign pop       = instr_valid & bus.InstrReady;

   // NOTE: every signal written in an always_comb gets a default first, otherwise
   // the paths that skip the assignment infer a latch.
   always_comb begin
      pc_we   = 1'b0;
      pc_next = '0;
      if (!RESET) begin
         if (state == INIT) begin
            pc_we   = 1'b1;
            pc_next = '0;
         end else if (redirect_live) begin
            pc_we   = 1'b1;
            pc_next = bus.RedirectTarget & ~ADDR_W'(3);
         end else if (accept) begin
            pc_we   = 1'b1;
            pc_next = bus.PCCur + ADDR_W'(4);
         end
      end
   end

   always_comb begin
      count_next = count;
      if (redirect_live) begin
         count_next = '0;
      end else if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (pop && !push) begin
         count_next = count - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state       <= INIT;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         instr_valid <= 1'b0;
         tag         <= '0;
      end else begin
         case (state)
            INIT:  state <= FETCH;
            FETCH: begin
               if (accept) begin
                  tag   <= bus.PCCur;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (redirect_live && !bus.IMemRespValid) begin
                  state <= DROP;
               end else if (bus.IMemRespValid) begin
                  state <= FETCH;
               end
            end
            // A redirect here just keeps waiting for the stale response; if that
            // response lands in the same cycle nothing is left outstanding.
            DROP: begin
               if (bus.IMemRespValid) begin
                  state <= FETCH;
               end
            end
            default: state <= INIT;
         endcase

         if (redirect_live) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
         end
         count       <= count_next;
         instr_valid <= (count_next != '0);
      end
   end

   // NOTE: the FIFO storage has no reset; count and pointers alone decide which
   // entries are meaningful, and leaving the array unreset keeps it plain RAM.
   always_ff @(posedge CLOCK) begin
      if (push) begin
         data_mem[wr_ptr] <= bus.IMemRespData;
         pc_mem[wr_ptr]   <= tag;
      end
   end

   assign bus.PCWE         = pc_we;
   assign bus.PCNext       = pc_next;
   assign bus.IMemReqValid = req_valid;
   assign bus.IMemReqAddr  = bus.PCCur;
   assign bus.InstrValid   = instr_valid;
   assign bus.InstrData    = data_mem[rd_ptr];
   assign bus.InstrPC      = pc_mem[rd_ptr];
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: plays PC register, instruction memory and decode, and
// checks the fetch/deliver streams against a sequential-program reference model.
module tb_fetch_sequencer;
   localparam int ADDR_W  = 64;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 2;

   logic CLOCK = 1'b0;
   logic RESET;

   fetch_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

   fetch_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLOCK = ~CLOCK;

   // PC register: no reset of its own, starts at garbage
   logic [63:0] pc_reg = 64'hBAD0_BAD0_BAD0_BAD0;
   always @(posedge CLOCK) if (bus.PCWE) pc_reg <= bus.PCNext;
   assign bus.PCCur = pc_reg;

   int tests = 0;
   int fails = 0;

   // memory model
   bit          mem_pending = 0;
   int          mem_timer   = 0;
   int          mem_lat     = 1;
   logic [63:0] mem_addr;

   // reference model: fetch and delivery are sequential from 0 / last target
   logic [63:0] next_req = '0;
   logic [63:0] next_del = '0;
   bit          in_init  = 0;
   bit          hold_en  = 0;
   logic [63:0] hold_pc  = '0;
   bit          prev_stall = 0;
   logic [63:0] prev_pc;
   logic [31:0] prev_data;

   logic [63:0] acc_log[$];
   logic [63:0] del_log[$];
   logic [63:0] wr_log[$];

   function automatic logic [31:0] word_of(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'hC0DE_5EED;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input bit rst, input bit redir, input logic [63:0] tgt,
                       input bit mrdy, input bit drdy);
      bit          acc;
      bit          exp_we;
      logic [63:0] exp_next;
      @(negedge CLOCK);
      RESET              = rst;
      bus.Redirect       = redir;
      bus.RedirectTarget = tgt;
      bus.IMemReqReady   = mrdy;
      bus.InstrReady     = drdy && !(hold_en && next_del == hold_pc);
      bus.IMemRespValid  = 1'b0;
      bus.IMemRespData   = $urandom;
      if (mem_pending) begin
         mem_timer--;
         if (mem_timer <= 0) begin
            bus.IMemRespValid = 1'b1;
            bus.IMemRespData  = word_of(mem_addr);
            mem_pending       = 0;
         end
      end
      #1;
      acc = bus.IMemReqValid && bus.IMemReqReady;
      if (rst) begin
         check("rst_pcwe", bus.PCWE, 0);
         check("rst_reqv", bus.IMemReqValid, 0);
         if (in_init) check("rst_instrv", bus.InstrValid, 0);
         next_req   = '0;
         next_del   = '0;
         prev_stall = 0;
         in_init    = 1;
      end else begin
         exp_we   = 1'b0;
         exp_next = '0;
         if (in_init) begin
            exp_we = 1'b1;
            check("init_reqv", bus.IMemReqValid, 0);
         end else if (redir) begin
            exp_we   = 1'b1;
            exp_next = tgt & ~64'd3;
         end else if (acc) begin
            exp_we   = 1'b1;
            exp_next = next_req + 64'd4;
         end
         check("pcwe", bus.PCWE, exp_we);
         if (exp_we) check("pcnext", bus.PCNext, exp_next);
         if (redir) check("redir_supp", bus.IMemReqValid, 0);
         if (bus.IMemReqValid) check("req_addr", bus.IMemReqAddr, pc_reg);
         if (acc) begin
            check("req_seq", bus.IMemReqAddr, next_req);
            check("one_outst", mem_pending, 0);
            acc_log.push_back(bus.IMemReqAddr);
            mem_pending = 1;
            mem_timer   = mem_lat;
            mem_addr    = bus.IMemReqAddr;
            next_req    = next_req + 64'd4;
         end
         if (prev_stall) begin
            check("hold_v", bus.InstrValid, 1);
            check("hold_pc", bus.InstrPC, prev_pc);
            check("hold_data", bus.InstrData, prev_data);
         end
         if (bus.InstrValid && bus.InstrReady) begin
            check("del_pc", bus.InstrPC, next_del);
            check("del_data", bus.InstrData, word_of(next_del));
            del_log.push_back(bus.InstrPC);
            next_del = next_del + 64'd4;
         end
         prev_stall = bus.InstrValid && !bus.InstrReady && !redir;
         prev_pc    = bus.InstrPC;
         prev_data  = bus.InstrData;
         if (redir && !in_init) begin
            next_req = tgt & ~64'd3;
            next_del = tgt & ~64'd3;
         end
         in_init = 0;
      end
      if (bus.PCWE) wr_log.push_back(bus.PCNext);
   endtask

   task automatic reset_dut();
      mem_pending = 0;
      hold_en     = 0;
      repeat (2) tick(1, 0, '0, 1, 1);
      acc_log.delete();
      del_log.delete();
      wr_log.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      bit last_r;
      int a0;
      int n0;
      logic [63:0] tgt;

      RESET              = 1'b1;
      bus.Redirect       = 1'b0;
      bus.RedirectTarget = '0;
      bus.IMemReqReady   = 1'b0;
      bus.IMemRespValid  = 1'b0;
      bus.IMemRespData   = '0;
      bus.InstrReady     = 1'b0;

      // 1: reset then free-running fetch, 1-cycle memory, decode always ready
      mem_lat = 1;
      reset_dut();
      tick(0, 0, '0, 1, 1);
      check("t1_pcwe_c1", bus.PCWE, 1);
      check("t1_pcnext_c1", bus.PCNext, 0);
      repeat (7) tick(0, 0, '0, 1, 1);
      check("t1_wr_n", wr_log.size(), 5);
      for (int i = 0; i < 4 && i < wr_log.size(); i++) check("t1_wr", wr_log[i], 64'(4 * i));
      check("t1_del_n", del_log.size(), 3);
      for (int i = 0; i < 3 && i < del_log.size(); i++) check("t1_del", del_log[i], 64'(4 * i));

      // 2: decode stalled, FIFO fills to DEPTH and fetch holds
      reset_dut();
      repeat (10) tick(0, 0, '0, 1, 0);
      check("t2_del_none", del_log.size(), 0);
      check("t2_acc_n", acc_log.size(), DEPTH);
      check("t2_instrv", bus.InstrValid, 1);
      check("t2_head_pc", bus.InstrPC, 0);
      check("t2_reqv", bus.IMemReqValid, 0);
      check("t2_pc_hold", pc_reg, 8);
      repeat (6) tick(0, 0, '0, 1, 1);
      check("t2_drain_n", del_log.size(), 4);
      for (int i = 0; i < 3 && i < del_log.size(); i++) check("t2_drain", del_log[i], 64'(4 * i));
      if (acc_log.size() > 2) check("t2_resume", acc_log[2], 8);
      else check("t2_resume_n", acc_log.size(), 3);

      // 3: redirect to 0x1003 while 0x10 is outstanding and 0xC is buffered
      reset_dut();
      mem_lat = 4;
      hold_en = 1;
      hold_pc = 64'hC;
      seen    = 0;
      for (int i = 0; i < 80 && !seen; i++) begin
         tick(0, 0, '0, 1, 1);
         seen = (acc_log.size() != 0) && (acc_log[acc_log.size() - 1] == 64'h10);
      end
      check("t3_reach", seen, 1);
      a0 = acc_log.size();
      n0 = del_log.size();
      tick(0, 1, 64'h1003, 1, 1);
      check("t3_pcwe", bus.PCWE, 1);
      check("t3_pcnext", bus.PCNext, 64'h1000);
      check("t3_buffered", bus.InstrValid, 1);
      hold_en = 0;
      tick(0, 0, '0, 1, 1);
      check("t3_flushed", bus.InstrValid, 0);
      check("t3_drop_noreq", bus.IMemReqValid, 0);
      mem_lat = 1;
      for (int i = 0; i < 40 && del_log.size() <= n0; i++) tick(0, 0, '0, 1, 1);
      check("t3_deliver", del_log.size() > n0, 1);
      if (del_log.size() > n0) check("t3_del_pc", del_log[n0], 64'h1000);
      if (acc_log.size() > a0) check("t3_req_pc", acc_log[a0], 64'h1000);

      // 4: redirect coinciding with a response and a pop
      reset_dut();
      mem_lat = 1;
      hold_en = 1;
      hold_pc = 64'h0;
      for (int i = 0; i < 20 && acc_log.size() < 2; i++) tick(0, 0, '0, 1, 1);
      check("t4_reach", acc_log.size(), 2);
      hold_en = 0;
      tick(0, 1, 64'h246A, 1, 1);
      check("t4_pop_head", bus.InstrPC, 0);
      check("t4_pop_v", bus.InstrValid, 1);
      tick(0, 0, '0, 1, 1);
      check("t4_count0", bus.InstrValid, 0);
      check("t4_reqv", bus.IMemReqValid, 1);
      check("t4_req_tgt", bus.IMemReqAddr, 64'h2468);
      repeat (4) tick(0, 0, '0, 1, 1);

      // 5: fetch at the top of the address space wraps PC to 0
      reset_dut();
      tick(0, 0, '0, 1, 1);
      tick(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1);
      tick(0, 0, '0, 1, 1);
      check("t5_addr", bus.IMemReqAddr, 64'hFFFF_FFFF_FFFF_FFFC);
      check("t5_pcwe", bus.PCWE, 1);
      check("t5_wrap", bus.PCNext, 0);
      repeat (5) tick(0, 0, '0, 1, 1);
      if (del_log.size() > 1) begin
         check("t5_del0", del_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
         check("t5_del1", del_log[1], 0);
      end else check("t5_del_n", del_log.size(), 2);

      // 6: one-cycle reset while waiting, stale response lands during INIT
      reset_dut();
      mem_lat = 2;
      tick(0, 0, '0, 1, 1);
      tick(0, 0, '0, 1, 1);
      check("t6_acc", acc_log.size(), 1);
      tick(1, 0, '0, 1, 1);
      tick(0, 0, '0, 1, 1);
      check("t6_init_pcwe", bus.PCWE, 1);
      check("t6_init_pc0", bus.PCNext, 0);
      mem_lat = 1;
      tick(0, 0, '0, 1, 1);
      check("t6_ignored", bus.InstrValid, 0);
      repeat (3) tick(0, 0, '0, 1, 1);
      if (del_log.size() > 0) check("t6_first", del_log[0], 0);
      else check("t6_first_n", del_log.size(), 1);

      // 7: randomized traffic, latency, stalls and redirects
      reset_dut();
      last_r = 0;
      for (int i = 0; i < 800; i++) begin
         bit r;
         mem_lat = $urandom_range(1, 3);
         r = !last_r && ($urandom_range(0, 99) < 4);
         case ($urandom_range(0, 2))
            0:       tgt = {$urandom, $urandom};
            1:       tgt = 64'($urandom_range(0, 4095));
            default: tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         endcase
         tick(0, r, tgt, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
         last_r = r;
      end
      repeat (20) tick(0, 0, '0, 1, 1);
      check("rnd_progress", del_log.size() > 50, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
